// File: rtl/llr_fg_pe_pipe.sv
// Two-stage polar SC-decoder processing element: per-beat f (min-sum) or g (partial-sum)
// update on LANES LLR pairs, with a sticky saturation-event counter. Optional macro: SCALED_MINSUM_EN.
module llr_fg_pe_pipe #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          mode,
  input  logic [LANES*DATA_WIDTH-1:0]   a_in,
  input  logic [LANES*DATA_WIDTH-1:0]   b_in,
  input  logic [LANES-1:0]              u_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_WIDTH-1:0]   llr_out,
  output logic [CNT_WIDTH-1:0]          sat_cnt,
  input  logic                          sat_clr
);

  localparam int unsigned W = DATA_WIDTH;

  typedef logic [W-2:0]        mag_t;
  typedef logic signed [W:0]   wide_t;

  localparam mag_t         MAG_MAX = '1;
  localparam logic [W-1:0] POS_W   = {1'b0, MAG_MAX};
  localparam logic [W-1:0] NEG_W   = -POS_W;
  localparam wide_t        POS_LIM = wide_t'({2'b00, MAG_MAX});
  localparam wide_t        NEG_LIM = -POS_LIM;

  // Magnitude with -2^(W-1) folded onto the largest legal magnitude.
  function automatic mag_t abs_sat(input logic [W-1:0] x);
    logic [W-1:0] nx;
    nx = -x;
    if (x[W-1] && (x[W-2:0] == '0)) abs_sat = MAG_MAX;
    else if (x[W-1])                abs_sat = nx[W-2:0];
    else                            abs_sat = x[W-2:0];
  endfunction

  logic                        s2_adv, s1_adv, in_fire, out_fire;

  logic                        s1_v_q, s1_v_d;
  logic                        s1_mode_q, s1_mode_d;
  logic [LANES-1:0][W-2:0]     s1_mag_q, s1_mag_d;
  logic [LANES-1:0]            s1_sgn_q, s1_sgn_d;
  logic [LANES-1:0][W:0]       s1_sum_q, s1_sum_d;

  logic                        s2_v_q, s2_v_d;
  logic                        s2_sat_q, s2_sat_d;
  logic [LANES*W-1:0]          llr_q, llr_d;

  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;

  assign s2_adv   = !s2_v_q || out_ready;
  assign s1_adv   = !s1_v_q || s2_adv;
  assign in_fire  = in_valid && s1_adv;
  assign out_fire = s2_v_q && out_ready;

  assign in_ready  = s1_adv;
  assign out_valid = s2_v_q;
  assign llr_out   = llr_q;
  assign sat_cnt   = cnt_q;

  // Stage 1: magnitudes, min, operand signs and the widened g sum.
  always_comb begin
    logic [W-1:0] a, b;
    mag_t         ma, mb;
    logic [W:0]   ax, bx;
    s1_v_d    = s1_v_q;
    s1_mode_d = s1_mode_q;
    s1_mag_d  = s1_mag_q;
    s1_sgn_d  = s1_sgn_q;
    s1_sum_d  = s1_sum_q;
    a  = '0;
    b  = '0;
    ma = '0;
    mb = '0;
    ax = '0;
    bx = '0;
    if (s1_adv) s1_v_d = in_valid;
    if (in_fire) begin
      s1_mode_d = mode;
      for (int unsigned i = 0; i < LANES; i++) begin
        a  = a_in[i*W +: W];
        b  = b_in[i*W +: W];
        ma = abs_sat(a);
        mb = abs_sat(b);
        ax = {a[W-1], a};
        bx = {b[W-1], b};
        s1_mag_d[i] = (ma < mb) ? ma : mb;
        s1_sgn_d[i] = a[W-1] ^ b[W-1];
        s1_sum_d[i] = u_in[i] ? (bx - ax) : (bx + ax);
      end
    end
  end

  // Stage 2: sign apply / clamp into the output register.
  always_comb begin
    mag_t             m;
    wide_t            sum;
    logic [W-1:0]     res;
    logic [LANES-1:0] lane_flag;
    s2_v_d    = s2_v_q;
    s2_sat_d  = s2_sat_q;
    llr_d     = llr_q;
    m         = '0;
    sum       = '0;
    res       = '0;
    lane_flag = '0;
    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          if (!s1_mode_q) begin
            m = s1_mag_q[i];
`ifdef SCALED_MINSUM_EN
            m = m - (m >> 2);
`endif
            // Two's-complement negation of a zero magnitude is zero, so no -0 can appear.
            res = s1_sgn_q[i] ? -{1'b0, m} : {1'b0, m};
          end else begin
            sum = wide_t'(s1_sum_q[i]);
            if (sum > POS_LIM) begin
              res          = POS_W;
              lane_flag[i] = 1'b1;
            end else if (sum < NEG_LIM) begin
              res          = NEG_W;
              lane_flag[i] = 1'b1;
            end else begin
              res = sum[W-1:0];
            end
          end
          llr_d[i*W +: W] = res;
        end
        s2_sat_d = |lane_flag;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (sat_clr)
      cnt_d = '0;
    else if (out_fire && s2_sat_q && !(&cnt_q))
      cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_mode_q <= 1'b0;
      s1_mag_q  <= '0;
      s1_sgn_q  <= '0;
      s1_sum_q  <= '0;
      s2_v_q    <= 1'b0;
      s2_sat_q  <= 1'b0;
      llr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_mode_q <= s1_mode_d;
      s1_mag_q  <= s1_mag_d;
      s1_sgn_q  <= s1_sgn_d;
      s1_sum_q  <= s1_sum_d;
      s2_v_q    <= s2_v_d;
      s2_sat_q  <= s2_sat_d;
      llr_q     <= llr_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_llr_fg_pe_pipe.sv
// Directed bench for llr_fg_pe_pipe (W=8, LANES=4): vector table plus backpressure,
// counter clear/saturation and mid-flight reset sequences.
module tb_llr_fg_pe_pipe;

  logic        clk, rst;
  logic        in_valid, in_ready, mode;
  logic [31:0] a_in, b_in;
  logic [3:0]  u_in;
  logic        out_valid, out_ready;
  logic [31:0] llr_out;
  logic [15:0] sat_cnt;
  logic        sat_clr;

  int total = 0;
  int bad   = 0;

  llr_fg_pe_pipe #(.DATA_WIDTH(8), .LANES(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .a_in(a_in), .b_in(b_in), .u_in(u_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .llr_out(llr_out), .sat_cnt(sat_cnt), .sat_clr(sat_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [3:0]  u;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        flag;
  } vec_t;

  vec_t tv[6];
  logic [31:0] rx[$];

  always @(posedge clk)
    if (!rst && out_valid && out_ready) rx.push_back(llr_out);

  function automatic logic [31:0] pk(input int l0, input int l1, input int l2, input int l3);
    pk = {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  initial begin
    int          exp_cnt;
    int          sent, cyc, waited;
    logic        acc;

    tv[0] = '{1'b0, 4'b1111, pk(-5, -128, 0, 7),    pk(3, -100, -7, -7),   '0, 1'b0};
    tv[1] = '{1'b0, 4'b0000, pk(8, 3, 127, -1),     pk(-12, 3, -127, 1),   '0, 1'b0};
    tv[2] = '{1'b1, 4'b0000, pk(100, -20, 0, -128), pk(100, 30, 0, -1),    pk(127, 10, 0, -127),  1'b1};
    tv[3] = '{1'b1, 4'b1111, pk(100, -20, 5, -128), pk(-100, 30, 5, 127),  pk(-127, 50, 0, 127),  1'b1};
    tv[4] = '{1'b1, 4'b0101, pk(-20, 10, -127, -60), pk(30, -30, 0, -67),  pk(50, -20, 127, -127), 1'b0};
    tv[5] = '{1'b0, 4'b1111, pk(-128, -128, 1, 0),  pk(-128, 127, -1, -7), '0, 1'b0};
`ifdef SCALED_MINSUM_EN
    tv[0].exp = pk(-3, 75, 0, -6);
    tv[1].exp = pk(-6, 3, -96, -1);
    tv[5].exp = pk(96, -96, -1, 0);
`else
    tv[0].exp = pk(-3, 100, 0, -7);
    tv[1].exp = pk(-8, 3, -127, -1);
    tv[5].exp = pk(127, -127, -1, 0);
`endif

    rst = 1'b1; in_valid = 1'b0; mode = 1'b0; a_in = '0; b_in = '0; u_in = '0;
    out_ready = 1'b1; sat_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_llr_out", llr_out, 0);
    chk("rst_sat_cnt", sat_cnt, 0);

    exp_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; mode = tv[i].mode; u_in = tv[i].u; a_in = tv[i].a; b_in = tv[i].b;
      #1 chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      mode = $urandom; u_in = $urandom; a_in = $urandom; b_in = $urandom;
      chk($sformatf("v%0d_lat1_ov", i), out_valid, 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_ov", i), out_valid, 1);
      chk($sformatf("v%0d_llr", i), llr_out, tv[i].exp);
      if (tv[i].flag) exp_cnt++;
      @(posedge clk); #1;
      chk($sformatf("v%0d_sat_cnt", i), sat_cnt, 32'(exp_cnt));
      chk($sformatf("v%0d_drained", i), out_valid, 0);
    end

    // Backpressure: five beats while the sink is blocked for the first four cycles.
    rx.delete();
    sent = 0; cyc = 0;
    while (sent < 5 && cyc < 40) begin
      @(negedge clk);
      out_ready = (cyc >= 4);
      in_valid = 1'b1; mode = 1'b1; u_in = 4'b0000;
      a_in = pk(sent + 1, -(sent + 1), 10 * sent, 0);
      b_in = pk(0, 0, 1, 0);
      #1;
      if (cyc == 2) chk("bp_in_ready_low_c2", in_ready, 0);
      if (cyc == 3) chk("bp_in_ready_low_c3", in_ready, 0);
      acc = in_ready;
      @(posedge clk);
      if (acc) sent++;
      cyc++;
    end
    chk("bp_all_sent", sent, 5);
    @(negedge clk) in_valid = 1'b0;
    waited = 0;
    while (rx.size() < 5 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("bp_rx_count", rx.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < rx.size()) chk($sformatf("bp_rx%0d", k), rx[k], pk(k + 1, -(k + 1), 10 * k + 1, 0));
    chk("bp_sat_cnt", sat_cnt, 2);

    // sat_clr coincident with a flagged output handshake.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; mode = 1'b1; u_in = 4'b0000; a_in = tv[2].a; b_in = tv[2].b;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    chk("clr_held_ov", out_valid, 1);
    @(negedge clk) begin out_ready = 1'b1; sat_clr = 1'b1; end
    @(posedge clk); #1;
    sat_clr = 1'b0;
    chk("clr_wins", sat_cnt, 0);

    // Reset with two beats in flight.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; mode = 1'b1; u_in = 4'b0000; a_in = pk(1, 2, 3, 4); b_in = pk(1, 1, 1, 1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) in_valid = 1'b0;
    #1 chk("mid_ov_before_rst", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_llr", llr_out, 0);
    @(negedge clk) begin rst = 1'b0; out_ready = 1'b1; end
    rx.delete();
    repeat (6) @(posedge clk);
    #1;
    chk("mid_no_stale", rx.size(), 0);
    chk("mid_ov_idle", out_valid, 0);

    // Counter saturation: 2^16+3 flagged beats streamed at full rate.
    @(negedge clk);
    in_valid = 1'b1; mode = 1'b1; u_in = 4'b0000; a_in = tv[2].a; b_in = tv[2].b;
    repeat (65539) @(posedge clk);
    @(negedge clk) in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("sat_hold_ffff", sat_cnt, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
